// File: rtl/io_interface_pkg.sv
// Definitions shared by the CUT I/O blocks (input buffer and output serializer).
// Includes the FSM state encoding, the default vector geometry and an index-width helper.
package io_interface_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 48;

  // Keeps a usable 1-bit index even for degenerate single-word vectors.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/output_serializer_if.sv
// Valid/ready word stream carrying serialized result words back to the host side.
// The serializer takes the master modport and the consumer takes the slave modport.
interface output_serializer_if
  import io_interface_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output out_valid,
    output out_last,
    output data_out,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_last,
    input  data_out,
    output out_ready
  );

endinterface

// File: rtl/output_serializer_word_mux.sv
// DEPTH:1 selector that picks one DATA_WIDTH slice of a packed vector by index.
// An index past the last word selects zero.
module word_mux
  import io_interface_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int IDX_W      = idx_width(DEPTH)
) (
  input  logic [DEPTH*DATA_WIDTH-1:0] data,
  input  logic [IDX_W-1:0]            sel,
  output logic [DATA_WIDTH-1:0]       word
);

  always_comb begin
    word = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sel == IDX_W'(k)) begin
        word = data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/output_serializer.sv
// Captures a wide result vector in one cycle and streams it out word 0 first over valid/ready.
// A done pulse follows the final transfer. A load is accepted only while the block is idle.
module output_serializer
  import io_interface_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int IDX_W      = idx_width(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [DEPTH*DATA_WIDTH-1:0] data_in,
  output_serializer_if.master         stream,
  output logic [IDX_W-1:0]            word_idx,
  output logic                        busy,
  output logic                        done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  ser_state_t                  state;
  ser_state_t                  next_state;
  logic [DEPTH*DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0]       mux_word;
  logic                        at_last;
  logic                        transfer;

  assign at_last  = (word_idx == LAST_IDX);
  assign transfer = (state == STREAM) && stream.out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load) next_state = STREAM;
      STREAM:  if (transfer && at_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The holding register is written only from IDLE, so a load that arrives mid-stream is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold     <= '0;
      word_idx <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            hold     <= data_in;
            word_idx <= '0;
          end
        end
        STREAM: begin
          if (transfer) begin
            if (at_last) begin
              word_idx <= '0;
              done     <= 1'b1;
            end else begin
              word_idx <= word_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          word_idx <= '0;
        end
      endcase
    end
  end

  word_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_word_mux (
    .data(hold),
    .sel (word_idx),
    .word(mux_word)
  );

  always_comb begin
    stream.out_valid = (state == STREAM);
    stream.out_last  = (state == STREAM) && at_last;
    stream.data_out  = mux_word;
    busy             = (state == STREAM);
  end

endmodule
